// File: rtl/gcd_client.sv
// gcd_client
//   Wraps an external GCD core as a single-job request/response client.
//   A job is accepted in IDLE. The operands are latched onto core_a/core_b.
//   The core is held in reset for one LAUNCH cycle and then released for RUN.
//   The result, or a timeout abort, is presented in RESP until the consumer
//   takes it.
//
// Ports
//   clk, nrst                  clock, async active-low reset
//   req_valid/req_ready        job request handshake
//   req_a, req_b               job operands
//   core_nrst                  active-low reset to the gcd core (high only in RUN)
//   core_a, core_b             operands held stable for the core
//   core_gcd, core_valid       core result and its one-cycle valid pulse
//   rsp_valid/rsp_ready        response handshake
//   rsp_gcd, rsp_timeout       captured result (0 on abort) and abort flag
//
// state  | meaning
// IDLE   | waiting for a job, req_ready=1
// LAUNCH | operands latched, core held in reset for one cycle
// RUN    | core released, counting cycles toward the timeout
// RESP   | response presented, waiting for rsp_ready
module gcd_client #(
  parameter int GCD_LENGTH = 14,
  parameter int TIMEOUT    = 20000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [GCD_LENGTH-1:0] req_a,
  input  logic [GCD_LENGTH-1:0] req_b,
  output logic                  core_nrst,
  output logic [GCD_LENGTH-1:0] core_a,
  output logic [GCD_LENGTH-1:0] core_b,
  input  logic [GCD_LENGTH-1:0] core_gcd,
  input  logic                  core_valid,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [GCD_LENGTH-1:0] rsp_gcd,
  output logic                  rsp_timeout
);

  // Gray-coded around the job loop: every legal transition flips exactly one
  // bit. Because of this, the single-state decodes below (core_nrst in
  // particular) cannot glitch.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    RUN    = 2'b11,
    RESP   = 2'b10
  } state_t;

  localparam logic [15:0] CNT_TC  = 16'(TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state;
  state_t      next_state;
  logic [15:0] cnt;
  logic        timed_out;

  assign timed_out = (cnt == CNT_TC);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid)               next_state = LAUNCH;
      LAUNCH:                               next_state = RUN;
      RUN:     if (core_valid || timed_out) next_state = RESP;
      RESP:    if (rsp_ready)               next_state = IDLE;
      default:                              next_state = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign core_nrst = (state == RUN);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      core_a      <= '0;
      core_b      <= '0;
      cnt         <= '0;
      rsp_gcd     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        core_a <= req_a;
        core_b <= req_b;
      end

      // Cleared on the way into RUN so the first RUN cycle sees zero.
      if (state == LAUNCH)
        cnt <= '0;
      else if (state == RUN && cnt != CNT_MAX)
        cnt <= cnt + 16'd1;

      // A late result arriving on the timeout cycle still wins.
      if (state == RUN) begin
        if (core_valid) begin
          rsp_gcd     <= core_gcd;
          rsp_timeout <= 1'b0;
        end else if (timed_out) begin
          rsp_gcd     <= '0;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_client.sv
module tb_gcd_client;
  localparam int GW  = 14;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          req_valid;
  logic          req_ready;
  logic [GW-1:0] req_a, req_b;
  logic          core_nrst;
  logic [GW-1:0] core_a, core_b;
  logic [GW-1:0] core_gcd;
  logic          core_valid;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [GW-1:0] rsp_gcd;
  logic          rsp_timeout;

  gcd_client #(.GCD_LENGTH(GW), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .core_nrst(core_nrst), .core_a(core_a), .core_b(core_b),
    .core_gcd(core_gcd), .core_valid(core_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_gcd(rsp_gcd), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int hs_count = 0;
  logic [GW:0] sb[$];   // {timeout, gcd}

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int unsigned gcd_f(int unsigned a, int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Reference: the core answers on RUN cycle 'lat' (1-based); any answer later
  // than TMO RUN cycles, or no answer at all, is a timeout abort.
  function automatic logic [GW:0] ref_resp(int unsigned a, int unsigned b, int lat, bit hang);
    if (hang || lat > TMO) return {1'b1, GW'(0)};
    return {1'b0, GW'(gcd_f(a, b))};
  endfunction

  // Behavioural core: released by core_nrst, answers after core_lat cycles.
  logic [15:0] run_cnt;
  int          core_lat = 1;
  bit          core_hang = 1'b0;
  logic        inj = 1'b0;

  always @(posedge clk) begin
    if (!core_nrst) run_cnt <= 16'd0;
    else            run_cnt <= run_cnt + 16'd1;
  end

  assign core_valid = inj | (core_nrst && !core_hang && run_cnt == 16'(core_lat - 1));
  assign core_gcd   = inj ? GW'(14'h2AAA) : GW'(gcd_f(core_a, core_b));

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (nrst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        logic [GW:0] e;
        e = sb.pop_front();
        chk("rsp_gcd", rsp_gcd, e[GW-1:0]);
        chk("rsp_timeout", rsp_timeout, e[GW]);
      end
      hs_count++;
    end
  end

  bit rand_bp = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(int unsigned a, int unsigned b, int lat, bit hang);
    int n = 0;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) begin chk("req_ready_wait", 0, 1); return; end
    core_lat  = lat;
    core_hang = hang;
    req_a     = GW'(a);
    req_b     = GW'(b);
    req_valid = 1'b1;
    sb.push_back(ref_resp(a & 32'h3FFF, b & 32'h3FFF, lat, hang));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 0);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("rsp_valid_wait", rsp_valid, 1);
  endtask

  initial begin
    int n, cycles, hs0;
    logic [GW-1:0] held;
    nrst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_core_nrst", core_nrst, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_gcd", rsp_gcd, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    @(negedge clk); nrst = 1'b1;

    // 12,18: LAUNCH, RUN, one-cycle RESP, back to IDLE
    issue(12, 18, 1, 0);
    @(negedge clk);
    chk("launch_req_ready", req_ready, 0);
    chk("launch_core_nrst", core_nrst, 0);
    chk("launch_core_a", core_a, 12);
    chk("launch_core_b", core_b, 18);
    @(negedge clk);
    chk("run_core_nrst", core_nrst, 1);
    @(negedge clk);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_gcd_6", rsp_gcd, 6);
    chk("resp_core_nrst", core_nrst, 0);
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);

    // back-to-back edge operands
    issue(16383, 1, 3, 0);
    issue(0, 5, 2, 0);
    issue(7, 7, 5, 0);
    drain();

    // hung core: exactly TMO RUN cycles then abort
    issue(100, 75, 1, 1);
    n = 0; cycles = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      if (core_nrst) cycles++;
      n++;
    end
    chk("tmo_run_cycles", cycles, TMO);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_timeout", rsp_timeout, 1);
    chk("tmo_rsp_gcd", rsp_gcd, 0);
    chk("tmo_core_nrst", core_nrst, 0);
    drain();

    // result on the timeout cycle wins; one cycle later loses
    issue(30, 45, TMO, 0);
    issue(30, 45, TMO + 1, 0);
    drain();

    // response backpressure
    @(posedge clk); #1 rsp_ready = 1'b0;
    hs0 = hs_count;
    issue(48, 36, 2, 0);
    wait_rsp();
    held = rsp_gcd;
    chk("bp_gcd_12", held, 12);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_gcd_stable", rsp_gcd, 12);
      chk("bp_req_ready", req_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_6th", rsp_valid, 1);
    chk("bp_gcd_6th", rsp_gcd, 12);
    @(negedge clk);
    chk("bp_released", rsp_valid, 0);
    chk("bp_req_ready_after", req_ready, 1);
    chk("bp_one_handshake", hs_count - hs0, 1);

    // reset mid-RUN aborts the job
    issue(9, 6, 1, 1);
    n = 0;
    while (!core_nrst && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("arst_core_nrst", core_nrst, 0);
    chk("arst_core_a", core_a, 0);
    chk("arst_core_b", core_b, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    chk("arst_rsp_gcd", rsp_gcd, 0);
    chk("arst_rsp_timeout", rsp_timeout, 0);
    sb.delete();
    hs0 = hs_count;
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    chk("arst_no_rsp", hs_count - hs0, 0);
    issue(9, 6, 3, 0);
    drain();

    // stray core_valid in IDLE
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    @(negedge clk);
    chk("inj_idle_gcd", rsp_gcd, 3);
    chk("inj_idle_req_ready", req_ready, 1);
    chk("inj_idle_rsp_valid", rsp_valid, 0);

    // stray core_valid in RESP
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(20, 15, 1, 0);
    wait_rsp();
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    @(negedge clk);
    chk("inj_resp_gcd", rsp_gcd, 5);
    chk("inj_resp_valid", rsp_valid, 1);
    chk("inj_resp_timeout", rsp_timeout, 0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();

    // randomized jobs with random backpressure
    rand_bp = 1'b1;
    for (int j = 0; j < 40; j++) begin
      int unsigned a, b;
      int mode;
      b = $urandom_range(0, 16383);
      a = $urandom_range(0, 16383);
      mode = $urandom_range(0, 4);
      if (mode == 0) a = 0;
      else if (mode == 1) a = b;
      else if (mode == 2) a = b * $urandom_range(1, 5);
      issue(a, b, $urandom_range(1, TMO + 2), 0);
    end
    drain();
    @(negedge clk);
    rand_bp = 1'b0;
    @(posedge clk); #2 rsp_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gcd_client.md
GCD_CLIENT -- requirements
Module: gcd_client

Interface
REQ-001 Parameter: GCD_LENGTH, default 14, operand and result width.
REQ-002 Parameter: TIMEOUT, default 20000, maximum RUN cycles before a job is aborted; 16-bit counter.
REQ-003 clk  input  1  single clock; all flops update on its rising edge.
REQ-004 nrst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  job request offered.
REQ-006 req_ready  output  1  block can accept a job.
REQ-007 req_a, req_b  input  GCD_LENGTH each  job operands.
REQ-008 core_nrst  output  1  active-low reset to the attached gcd core.
REQ-009 core_a, core_b  output  GCD_LENGTH each  operands driven to the core.
REQ-010 core_gcd  input  GCD_LENGTH  core result.
REQ-011 core_valid  input  1  core one-cycle result-valid pulse.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_gcd  output  GCD_LENGTH  captured result, or 0 on timeout.
REQ-015 rsp_timeout  output  1  response is a timeout abort.

Function
REQ-016 The block SHALL implement the states IDLE, LAUNCH, RUN and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-018 On accept, req_a/req_b SHALL be registered into core_a/core_b and the state SHALL go IDLE->LAUNCH.
REQ-019 core_a/core_b SHALL hold their values from accept until the next accept.
REQ-020 core_nrst SHALL be 1 only in RUN, decoded from the state register so it is glitch-free, and 0 in IDLE, LAUNCH and RESP.
REQ-021 LAUNCH SHALL last exactly one cycle and then go to RUN, so the core sees at least one low cycle of core_nrst with stable operands.
REQ-022 Entering RUN SHALL clear the cycle counter; the counter SHALL increment by 1 on each RUN cycle and SHALL saturate rather than wrap.
REQ-023 In RUN, core_valid=1 SHALL capture core_gcd into rsp_gcd, clear rsp_timeout and go to RESP on the same edge.
REQ-024 In RUN, if the counter equals TIMEOUT-1 and core_valid=0, the block SHALL set rsp_gcd=0 and rsp_timeout=1 and go to RESP.
REQ-025 If core_valid and the timeout condition occur in the same cycle, core_valid SHALL take priority.
REQ-026 core_valid SHALL be ignored outside RUN.
REQ-027 rsp_valid SHALL be 1 only in RESP, asserted the cycle after the capture edge.
REQ-028 rsp_gcd and rsp_timeout SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-029 In RESP, rsp_ready=1 SHALL complete the handshake and return the state to IDLE; req_ready SHALL be 1 on the next cycle.
REQ-030 The block SHALL never accept a new request in the same cycle as a response handshake; there is one job in flight at most.
REQ-031 rsp_ready held at 1 continuously SHALL cause RESP to last exactly one cycle.
REQ-032 Operand values SHALL pass through unmodified; a=0, b=0 and a=b SHALL all be forwarded without special handling.
REQ-033 An undefined state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-034 nrst=0 SHALL immediately force the following, independent of clk:
- state = IDLE;
- core_nrst = 0;
- core_a = core_b = 0;
- counter = 0;
- rsp_valid = 0, rsp_gcd = 0, rsp_timeout = 0.
REQ-035 A reset asserted in LAUNCH, RUN or RESP SHALL abort the job with no response issued.
REQ-036 The first accept SHALL be possible on the first rising edge after nrst rises.

Verification
REQ-037 Request a=12, b=18 with rsp_ready=1 -> the sequence is LAUNCH then RUN, then rsp_valid for one cycle with rsp_gcd=6 and rsp_timeout=0, then req_ready=1.
REQ-038 Request a=16383, b=1, then a=0, b=5, then a=7, b=7 back-to-back -> responses 1, 5 and 7 in order, each with rsp_timeout=0.
REQ-039 Core model that never pulses core_valid, with TIMEOUT=8 -> after exactly 8 RUN cycles rsp_valid=1, rsp_timeout=1, rsp_gcd=0, and core_nrst falls to 0.
REQ-040 Response backpressure: rsp_ready=0 for 5 cycles, then 1 -> rsp_valid and rsp_gcd held stable for 6 cycles, req_ready=0 throughout, one handshake only.
REQ-041 nrst pulsed low mid-RUN of a=9, b=6 -> outputs take reset values asynchronously, no response is produced, and a subsequent job a=9, b=6 returns 3.
REQ-042 core_valid pulse injected in IDLE and in RESP -> no state change and rsp_gcd unchanged.
